fifo_mux_out: RTL and testbench

- Synchronous FIFO that sits directly downstream of the 2:1 valid-arbitrated mux.
- Captures every mux output beat (8-bit data tagged by valid) and buffers it for the next consumer, which drains with a pop strobe.
- Provides full/empty and programmable almost-full/almost-empty flags so upstream flow can be throttled.
- Flags overflow and underflow misuse as sticky errors.

---
 rtl/fifo_mux_out_pkg.sv | 30 +++
 rtl/fifo_mux_out_if.sv | 34 +++
 rtl/fifo_mux_out_mem.sv | 34 +++
 rtl/fifo_mux_out.sv | 113 +++++++++++
 tb/tb_fifo_mux_out.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_mux_out_pkg.sv
// Shared widths, thresholds and the status-flag payload for the mux-output FIFO.
// Imported by the FIFO, its storage sub-module, its interface and the bench so
// every party agrees on word width, depth and flag thresholds.
package fifo_mux_out_pkg;

    localparam int unsigned DEF_DATA_WIDTH      = 8;
    localparam int unsigned DEF_ADDR_WIDTH      = 2;
    localparam int unsigned DEF_ALMOST_FULL_TH  = 3;
    localparam int unsigned DEF_ALMOST_EMPTY_TH = 1;

    // Registered status flags, grouped so they reset and update as one word.
    typedef struct packed {
        logic fifo_full;
        logic fifo_empty;
        logic almost_full;
        logic almost_empty;
        logic overflow_err;
        logic underflow_err;
    } fifo_status_t;

    localparam fifo_status_t STATUS_RST = '{
        fifo_full:     1'b0,
        fifo_empty:    1'b1,
        almost_full:   1'b0,
        almost_empty:  1'b1,
        overflow_err:  1'b0,
        underflow_err: 1'b0
    };

endpackage

// File: rtl/fifo_mux_out_if.sv
// Handshake/data bundle between the mux, the FIFO and the downstream consumer.
//   master : drives data_in/valid_in (from mux) and pop (from consumer)
//   slave  : the FIFO; returns data_out/valid_out and all status flags
interface fifo_mux_out_if
    import fifo_mux_out_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow_err;
    logic                  underflow_err;

    modport master (
        output data_in, valid_in, pop,
        input  data_out, valid_out, fifo_full, fifo_empty,
               almost_full, almost_empty, overflow_err, underflow_err
    );

    modport slave (
        input  data_in, valid_in, pop,
        output data_out, valid_out, fifo_full, fifo_empty,
               almost_full, almost_empty, overflow_err, underflow_err
    );

endinterface

// File: rtl/fifo_mux_out_mem.sv
// Register-array storage for the FIFO: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
//   clk     : write clock
//   wr_en_i, wr_addr_i, wr_data_i : write port
//   rd_addr_i, rd_data_o          : combinational read port
module fifo_mux_out_mem
    import fifo_mux_out_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port
    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo_mux_out.sv
// Synchronous FIFO buffering the 2:1 mux output beats for a pop-driven consumer.
// Provides full/empty, programmable almost-full/almost-empty and sticky
// overflow/underflow error flags.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of fifo_mux_out_if (push/pop in, data/flags out)
module fifo_mux_out
    import fifo_mux_out_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int unsigned ALMOST_FULL_TH  = DEF_ALMOST_FULL_TH,
    parameter int unsigned ALMOST_EMPTY_TH = DEF_ALMOST_EMPTY_TH
) (
    input  logic          clk,
    input  logic          reset,
    fifo_mux_out_if.slave bus
);

    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q,  count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    fifo_status_t          status_q, status_d;

    logic                  push_ok;
    logic                  pop_ok;
    logic [DATA_WIDTH-1:0] rd_data;

    // Acceptance is judged on the registered flags, i.e. the pre-edge count.
    assign push_ok = bus.valid_in & ~status_q.fifo_full;
    assign pop_ok  = bus.pop      & ~status_q.fifo_empty;

    fifo_mux_out_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (push_ok),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (bus.data_in),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    // Next-state: pointers, occupancy, read register and flags
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        status_d    = status_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end

        if (pop_ok) begin
            rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
            data_out_d  = rd_data;
            valid_out_d = 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase

        // Flags are decoded from the next count so they are valid from the
        // cycle after the causing edge, exactly like a decode of count_q.
        status_d.fifo_full     = (count_d == CNT_WIDTH'(DEPTH));
        status_d.fifo_empty    = (count_d == '0);
        status_d.almost_full   = (count_d >= CNT_WIDTH'(ALMOST_FULL_TH));
        status_d.almost_empty  = (count_d <= CNT_WIDTH'(ALMOST_EMPTY_TH));
        status_d.overflow_err  = status_q.overflow_err  | (bus.valid_in & status_q.fifo_full);
        status_d.underflow_err = status_q.underflow_err | (bus.pop & status_q.fifo_empty);
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            status_q    <= STATUS_RST;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            status_q    <= status_d;
        end
    end

    assign bus.data_out      = data_out_q;
    assign bus.valid_out     = valid_out_q;
    assign bus.fifo_full     = status_q.fifo_full;
    assign bus.fifo_empty    = status_q.fifo_empty;
    assign bus.almost_full   = status_q.almost_full;
    assign bus.almost_empty  = status_q.almost_empty;
    assign bus.overflow_err  = status_q.overflow_err;
    assign bus.underflow_err = status_q.underflow_err;

endmodule

// File: tb/tb_fifo_mux_out.sv
// Self-checking bench for fifo_mux_out: directed scenarios followed by random
// push/pop traffic, all compared against a queue-based reference model.
module tb_fifo_mux_out;
    import fifo_mux_out_pkg::*;

    localparam int unsigned DEPTH = 1 << DEF_ADDR_WIDTH;

    logic clk;
    logic reset;

    fifo_mux_out_if #(.DATA_WIDTH(DEF_DATA_WIDTH)) bus ();

    fifo_mux_out dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_dout;
    logic       m_vout;
    logic       m_ovf;
    logic       m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout = 8'h00;
        m_vout = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // One clock edge of the reference behaviour, evaluated on pre-edge occupancy.
    task automatic model_edge(input logic v, input logic [7:0] d, input logic p);
        int n;
        n = m_q.size();
        if (v && n == DEPTH) m_ovf = 1'b1;
        if (p && n == 0)     m_unf = 1'b1;
        if (p && n > 0) begin
            m_dout = m_q.pop_front();
            m_vout = 1'b1;
        end else begin
            m_vout = 1'b0;
        end
        if (v && n < DEPTH) m_q.push_back(d);
    endtask

    task automatic check_all(input string tag);
        int n;
        n = m_q.size();
        chk({tag, ".data_out"},      32'(bus.data_out),      32'(m_dout));
        chk({tag, ".valid_out"},     32'(bus.valid_out),     32'(m_vout));
        chk({tag, ".fifo_full"},     32'(bus.fifo_full),     32'(n == DEPTH));
        chk({tag, ".fifo_empty"},    32'(bus.fifo_empty),    32'(n == 0));
        chk({tag, ".almost_full"},   32'(bus.almost_full),   32'(n >= DEF_ALMOST_FULL_TH));
        chk({tag, ".almost_empty"},  32'(bus.almost_empty),  32'(n <= DEF_ALMOST_EMPTY_TH));
        chk({tag, ".overflow_err"},  32'(bus.overflow_err),  32'(m_ovf));
        chk({tag, ".underflow_err"}, 32'(bus.underflow_err), 32'(m_unf));
    endtask

    // Drive one cycle (called at posedge+1), step the model, check at next posedge+1.
    task automatic step(input string tag, input logic v, input logic [7:0] d, input logic p);
        bus.valid_in = v;
        bus.data_in  = d;
        bus.pop      = p;
        model_edge(v, d, p);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset applied between edges, held two edges, then released.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".async"});
        repeat (2) @(posedge clk);
        #1;
        check_all({tag, ".held"});
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        reset        = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hff;
        bus.pop      = 1'b0;
        model_reset();

        // Reset with a push pending must store nothing
        #1;
        check_all("rst0");
        repeat (2) @(posedge clk);
        #1;
        check_all("rst2");
        chk("rst.data_out", 32'(bus.data_out), 32'h00);
        bus.valid_in = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check_all("rst_idle");

        // Fill, flags, overflow
        step("fill0", 1'b1, 8'hff, 1'b0);
        step("fill1", 1'b1, 8'hee, 1'b0);
        chk("fill1.ae_low", 32'(bus.almost_empty), 32'h0);
        step("fill2", 1'b1, 8'hdd, 1'b0);
        chk("fill2.af_high", 32'(bus.almost_full), 32'h1);
        step("fill3", 1'b1, 8'hcc, 1'b0);
        chk("fill3.full", 32'(bus.fifo_full), 32'h1);
        step("ovf", 1'b1, 8'hbb, 1'b0);
        chk("ovf.flag", 32'(bus.overflow_err), 32'h1);

        // Drain in order, then underflow
        step("drain0", 1'b0, 8'h00, 1'b1);
        chk("drain0.val", 32'(bus.data_out), 32'hff);
        step("drain1", 1'b0, 8'h00, 1'b1);
        chk("drain1.val", 32'(bus.data_out), 32'hee);
        step("drain2", 1'b0, 8'h00, 1'b1);
        chk("drain2.val", 32'(bus.data_out), 32'hdd);
        step("drain3", 1'b0, 8'h00, 1'b1);
        chk("drain3.val", 32'(bus.data_out), 32'hcc);
        step("unf", 1'b0, 8'h00, 1'b1);
        chk("unf.flag", 32'(bus.underflow_err), 32'h1);
        chk("unf.hold", 32'(bus.data_out), 32'hcc);
        step("idle", 1'b0, 8'h00, 1'b0);

        // Wrap-around of both pointers
        do_reset("wrap_rst");
        for (int i = 0; i < 3; i++) step("wrap_push", 1'b1, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 3; i++) step("wrap_pop", 1'b0, 8'h00, 1'b1);
        step("wrap_w33", 1'b1, 8'h33, 1'b0);
        step("wrap_w44", 1'b1, 8'h44, 1'b0);
        step("wrap_w55", 1'b1, 8'h55, 1'b0);
        step("wrap_r33", 1'b0, 8'h00, 1'b1);
        chk("wrap_r33.val", 32'(bus.data_out), 32'h33);
        step("wrap_r44", 1'b0, 8'h00, 1'b1);
        chk("wrap_r44.val", 32'(bus.data_out), 32'h44);
        step("wrap_r55", 1'b0, 8'h00, 1'b1);
        chk("wrap_r55.val", 32'(bus.data_out), 32'h55);

        // Simultaneous push+pop at count 2
        do_reset("sim_rst");
        step("sim_waa", 1'b1, 8'haa, 1'b0);
        step("sim_w55", 1'b1, 8'h55, 1'b0);
        step("sim_both", 1'b1, 8'h99, 1'b1);
        chk("sim_both.val", 32'(bus.data_out), 32'haa);
        step("sim_r55", 1'b0, 8'h00, 1'b1);
        step("sim_r99", 1'b0, 8'h00, 1'b1);
        chk("sim_r99.val", 32'(bus.data_out), 32'h99);

        // Simultaneous push+pop at full
        do_reset("simf_rst");
        for (int i = 0; i < 4; i++) step("simf_fill", 1'b1, 8'(8'h20 + i), 1'b0);
        step("simf_both", 1'b1, 8'h99, 1'b1);
        chk("simf.ovf", 32'(bus.overflow_err), 32'h1);
        chk("simf.val", 32'(bus.data_out), 32'h20);
        for (int i = 0; i < 3; i++) step("simf_drain", 1'b0, 8'h00, 1'b1);
        chk("simf.last", 32'(bus.data_out), 32'h23);

        // Simultaneous push+pop at empty: no fall-through
        do_reset("sime_rst");
        step("sime_both", 1'b1, 8'h5a, 1'b1);
        chk("sime.unf", 32'(bus.underflow_err), 32'h1);
        chk("sime.vout", 32'(bus.valid_out), 32'h0);
        step("sime_pop", 1'b0, 8'h00, 1'b1);
        chk("sime.val", 32'(bus.data_out), 32'h5a);

        // Reset mid-stream with a pop pending before the edge
        do_reset("mid_rst0");
        for (int i = 0; i < 3; i++) step("mid_fill", 1'b1, 8'(8'h40 + i), 1'b0);
        bus.valid_in = 1'b0;
        bus.pop      = 1'b1;
        do_reset("mid_rst");
        bus.pop = 1'b0;
        step("mid_w77", 1'b1, 8'h77, 1'b0);
        step("mid_r77", 1'b0, 8'h00, 1'b1);
        chk("mid_r77.val", 32'(bus.data_out), 32'h77);

        // Random traffic against the model
        do_reset("rnd_rst");
        for (int i = 0; i < 400; i++) begin
            rd = 8'($urandom);
            step("rnd", 1'($urandom_range(0, 99) < 55), rd, 1'($urandom_range(0, 99) < 50));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
